// File: rtl/ultrasonic_multi_ranger_pkg.sv
// Shared types and constants for the multi-channel HC-SR04 ranging controller.
package ultrasonic_multi_ranger_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StTrig,
      StWaitEcho,
      StMeas,
      StDone,
      StGap
   } state_e;

   localparam int unsigned UsPerCm = 58;

   // Index width that stays at least one bit wide for a single-channel build.
   function automatic int unsigned clog2_min1(input int unsigned n);
      int unsigned w;
      w = 0;
      while ((32'd1 << w) < n) begin
         w++;
      end
      return (w == 0) ? 1 : w;
   endfunction

endpackage

// File: rtl/ultrasonic_multi_ranger_us_tick_gen.sv
// Microsecond strobe prescaler with synchronous restart.
module ultrasonic_multi_ranger_us_tick_gen #(
   parameter int unsigned Div = 125
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   output logic tick_o
);

   localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
   localparam logic [CntW-1:0] Last = CntW'(Div - 1);
   // The clear cycle itself counts, so the first tick lands Div clocks after the restart edge.
   localparam logic [CntW-1:0] Restart = (Div > 1) ? CntW'(1) : '0;

   logic [CntW-1:0] cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= Restart;
      end else if (cnt_q == Last) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CntW'(1);
      end
   end

   assign tick_o = clr_i ? (Div == 1) : (cnt_q == Last);

endmodule

// File: rtl/ultrasonic_multi_ranger.sv
// Round-robin HC-SR04 ranging controller for NUM_CH sensors with per-channel timeout flags.
// Define ULTRASONIC_AVG_EN to store the average of the new and previous good reading.
module ultrasonic_multi_ranger
   import ultrasonic_multi_ranger_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 125_000_000,
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned DIST_W     = 9,
   parameter int unsigned TRIG_US    = 10,
   parameter int unsigned TIMEOUT_US = 30000,
   parameter int unsigned GAP_US     = 5000,
   localparam int unsigned ChW       = clog2_min1(NUM_CH)
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     start_i,
   input  logic                     continuous_i,
   input  logic [NUM_CH-1:0]        echo_i,
   output logic [NUM_CH-1:0]        trig_o,
   output logic [NUM_CH*DIST_W-1:0] distance_o,
   output logic [NUM_CH-1:0]        timeout_o,
   output logic                     dist_valid_o,
   output logic [ChW-1:0]           valid_ch_o,
   output logic                     busy_o
);

   localparam int unsigned TickDiv = CLK_HZ / 1_000_000;
   localparam int unsigned MaxTg   = (TRIG_US > GAP_US) ? TRIG_US : GAP_US;
   localparam int unsigned MaxUs   = (TIMEOUT_US > MaxTg) ? TIMEOUT_US : MaxTg;
   localparam int unsigned UsW     = $clog2(MaxUs + 1);
   localparam int unsigned CmDivW  = $clog2(UsPerCm);
   localparam logic [DIST_W-1:0] DistMax = '1;

   state_e                         state_q;
   logic [ChW-1:0]                 ch_q;
   logic [ChW-1:0]                 ch_nxt;
   logic [UsW-1:0]                 us_cnt_q;
   logic [CmDivW-1:0]              cm_div_q;
   logic [DIST_W-1:0]              cm_q;
   logic                           err_q;
   logic                           tclr_q;
   logic                           valid_q;
   logic [ChW-1:0]                 valid_ch_q;
   logic                           echo_prev_q;
   logic [NUM_CH-1:0]              echo_meta_q;
   logic [NUM_CH-1:0]              echo_sync_q;
   logic [NUM_CH-1:0]              trig_q;
   logic [NUM_CH-1:0]              timeout_q;
   logic [NUM_CH-1:0][DIST_W-1:0]  dist_q;
   logic [DIST_W-1:0]              dist_new;
   logic                           us_tick;
   logic                           echo_sel;
   logic                           echo_rise;

   ultrasonic_multi_ranger_us_tick_gen #(
      .Div (TickDiv)
   ) u_tick (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (tclr_q),
      .tick_o (us_tick)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         echo_meta_q <= '0;
         echo_sync_q <= '0;
      end else begin
         echo_meta_q <= echo_i;
         echo_sync_q <= echo_meta_q;
      end
   end

   assign echo_sel  = echo_sync_q[ch_q];
   assign echo_rise = echo_sel & ~echo_prev_q;
   assign ch_nxt    = ch_q + ChW'(1);

`ifdef ULTRASONIC_AVG_EN
   logic [NUM_CH-1:0] have_prev_q;
   logic [DIST_W:0]   avg_sum;

   always_comb begin
      avg_sum  = {1'b0, cm_q} + {1'b0, dist_q[ch_q]};
      dist_new = have_prev_q[ch_q] ? avg_sum[DIST_W:1] : cm_q;
   end

   // A timeout forgets the history so the next good reading is stored as-is.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         have_prev_q <= '0;
      end else if (state_q == StDone) begin
         have_prev_q[ch_q] <= ~err_q;
      end
   end
`else
   assign dist_new = cm_q;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         ch_q        <= '0;
         us_cnt_q    <= '0;
         cm_div_q    <= '0;
         cm_q        <= '0;
         err_q       <= 1'b0;
         tclr_q      <= 1'b0;
         valid_q     <= 1'b0;
         valid_ch_q  <= '0;
         echo_prev_q <= 1'b0;
         trig_q      <= '0;
         timeout_q   <= '0;
         dist_q      <= '0;
      end else begin
         valid_q     <= 1'b0;
         tclr_q      <= 1'b0;
         echo_prev_q <= echo_sel;
         unique case (state_q)
            StIdle: begin
               if (start_i || continuous_i) begin
                  ch_q      <= '0;
                  trig_q[0] <= 1'b1;
                  us_cnt_q  <= '0;
                  tclr_q    <= 1'b1;
                  state_q   <= StTrig;
               end
            end
            StTrig: begin
               if (us_tick) begin
                  if (us_cnt_q == UsW'(TRIG_US - 1)) begin
                     trig_q   <= '0;
                     us_cnt_q <= '0;
                     tclr_q   <= 1'b1;
                     state_q  <= StWaitEcho;
                  end else begin
                     us_cnt_q <= us_cnt_q + UsW'(1);
                  end
               end
            end
            StWaitEcho: begin
               if (echo_rise) begin
                  us_cnt_q <= '0;
                  cm_div_q <= '0;
                  cm_q     <= '0;
                  tclr_q   <= 1'b1;
                  state_q  <= StMeas;
               end else if (us_tick) begin
                  if (us_cnt_q == UsW'(TIMEOUT_US - 1)) begin
                     err_q   <= 1'b1;
                     state_q <= StDone;
                  end else begin
                     us_cnt_q <= us_cnt_q + UsW'(1);
                  end
               end
            end
            StMeas: begin
               // The tick coinciding with the observed fall still counts toward the echo time.
               if (us_tick) begin
                  if (cm_div_q == CmDivW'(UsPerCm - 1)) begin
                     cm_div_q <= '0;
                     if (cm_q != DistMax) begin
                        cm_q <= cm_q + DIST_W'(1);
                     end
                  end else begin
                     cm_div_q <= cm_div_q + CmDivW'(1);
                  end
               end
               if (!echo_sel) begin
                  err_q   <= 1'b0;
                  state_q <= StDone;
               end else if (us_tick) begin
                  if (us_cnt_q == UsW'(TIMEOUT_US - 1)) begin
                     err_q   <= 1'b1;
                     state_q <= StDone;
                  end else begin
                     us_cnt_q <= us_cnt_q + UsW'(1);
                  end
               end
            end
            StDone: begin
               dist_q[ch_q]    <= err_q ? DistMax : dist_new;
               timeout_q[ch_q] <= err_q;
               valid_q         <= 1'b1;
               valid_ch_q      <= ch_q;
               us_cnt_q        <= '0;
               state_q         <= StGap;
            end
            StGap: begin
               if (us_tick) begin
                  if (us_cnt_q == UsW'(GAP_US - 1)) begin
                     us_cnt_q <= '0;
                     if (ch_q != ChW'(NUM_CH - 1)) begin
                        ch_q           <= ch_nxt;
                        trig_q[ch_nxt] <= 1'b1;
                        tclr_q         <= 1'b1;
                        state_q        <= StTrig;
                     end else begin
                        ch_q <= '0;
                        if (continuous_i) begin
                           trig_q[0] <= 1'b1;
                           tclr_q    <= 1'b1;
                           state_q   <= StTrig;
                        end else begin
                           state_q <= StIdle;
                        end
                     end
                  end else begin
                     us_cnt_q <= us_cnt_q + UsW'(1);
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign trig_o       = trig_q;
   assign distance_o   = dist_q;
   assign timeout_o    = timeout_q;
   assign dist_valid_o = valid_q;
   assign valid_ch_o   = valid_ch_q;
   assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_ultrasonic_multi_ranger.sv
// Directed bench for ultrasonic_multi_ranger; expectations follow ULTRASONIC_AVG_EN when defined.
module tb_ultrasonic_multi_ranger;

   localparam int unsigned CLK_HZ     = 2_000_000;
   localparam int unsigned NUM_CH     = 4;
   localparam int unsigned DIST_W     = 6;
   localparam int unsigned TRIG_US    = 10;
   localparam int unsigned TIMEOUT_US = 4000;
   localparam int unsigned GAP_US     = 20;
   localparam int          Div        = 2;
   localparam int          DistMax    = 63;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic                     start = 1'b0;
   logic                     continuous = 1'b0;
   logic [NUM_CH-1:0]        echo = '0;
   logic [NUM_CH-1:0]        trig;
   logic [NUM_CH*DIST_W-1:0] distance;
   logic [NUM_CH-1:0]        timeout;
   logic                     dist_valid;
   logic [1:0]               valid_ch;
   logic                     busy;

   int checks = 0;
   int errors = 0;
   int model_dist [NUM_CH];
   bit model_have [NUM_CH];

   ultrasonic_multi_ranger #(
      .CLK_HZ     (CLK_HZ),
      .NUM_CH     (NUM_CH),
      .DIST_W     (DIST_W),
      .TRIG_US    (TRIG_US),
      .TIMEOUT_US (TIMEOUT_US),
      .GAP_US     (GAP_US)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .start_i      (start),
      .continuous_i (continuous),
      .echo_i       (echo),
      .trig_o       (trig),
      .distance_o   (distance),
      .timeout_o    (timeout),
      .dist_valid_o (dist_valid),
      .valid_ch_o   (valid_ch),
      .busy_o       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NUM_CH; i++) begin
         model_dist[i] = 0;
         model_have[i] = 1'b0;
      end
   endtask

   task automatic predict(input int k, input int high_us, input bit err, output int v);
      int raw;
      if (err) begin
         v = DistMax;
         model_have[k] = 1'b0;
      end else begin
         raw = high_us / 58;
         if (raw > DistMax) raw = DistMax;
`ifdef ULTRASONIC_AVG_EN
         v = model_have[k] ? (raw + model_dist[k]) / 2 : raw;
`else
         v = raw;
`endif
         model_have[k] = 1'b1;
      end
      model_dist[k] = v;
   endtask

   task automatic start_pulse();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // no_pulse: the channel never sees a rising edge, so it must time out.
   task automatic run_ch(input int k, input int delay_us, input int high_us, input bit no_pulse);
      int n;
      int v;
      n = 0;
      while (trig == '0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("trig_onehot_ch%0d", k), 32'(trig), 32'(1 << k));
      n = 0;
      while (trig != '0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("trig_width_ch%0d", k), 32'(n), 32'(TRIG_US * Div));
      if (!no_pulse) begin
         repeat (delay_us * Div) @(negedge clk);
         echo[k] = 1'b1;
         repeat (high_us * Div) @(negedge clk);
         echo[k] = 1'b0;
      end
      n = 0;
      while (!dist_valid && n < TIMEOUT_US * Div * 2 + 100) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("valid_seen_ch%0d", k), 32'(dist_valid), 32'd1);
      predict(k, high_us, no_pulse, v);
      check($sformatf("valid_ch_ch%0d", k), 32'(valid_ch), 32'(k));
      check($sformatf("distance_ch%0d", k), 32'(distance[k*DIST_W +: DIST_W]), 32'(v));
      check($sformatf("timeout_ch%0d", k), 32'(timeout[k]), 32'(no_pulse));
      @(negedge clk);
      check($sformatf("valid_pulse_ch%0d", k), 32'(dist_valid), 32'd0);
   endtask

   initial begin
      int n;
      model_reset();

      // Reset with echo toggling
      repeat (6) begin
         @(negedge clk);
         echo = ~echo;
      end
      check("rst_trig", 32'(trig), 32'd0);
      check("rst_distance", 32'(distance), 32'd0);
      check("rst_timeout", 32'(timeout), 32'd0);
      check("rst_valid", 32'(dist_valid), 32'd0);
      check("rst_valid_ch", 32'(valid_ch), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      echo = '0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);

      // Single sweep: ch2 gets no echo; a start while busy is ignored
      start_pulse();
      check("sweep1_busy", 32'(busy), 32'd1);
      run_ch(0, 30, 580, 1'b0);
      start_pulse();
      run_ch(1, 30, 58, 1'b0);
      run_ch(2, 30, 0, 1'b1);
      run_ch(3, 30, 116, 1'b0);
      repeat (GAP_US * Div + 20) @(negedge clk);
      check("sweep1_idle", 32'(busy), 32'd0);
      check("sweep1_no_retrig", 32'(trig), 32'd0);

      // Second sweep: ch2 recovers; ch0 goes 10 -> 20 cm
      start_pulse();
      run_ch(0, 20, 1160, 1'b0);
      run_ch(1, 20, 174, 1'b0);
      run_ch(2, 20, 580, 1'b0);
      run_ch(3, 20, 232, 1'b0);
      repeat (GAP_US * Div + 20) @(negedge clk);
      check("sweep2_idle", 32'(busy), 32'd0);
      check("sweep2_timeouts", 32'(timeout), 32'd0);

      // Continuous: order 0,1,2,3,0 then drop mid-sweep and finish it
      continuous = 1'b1;
      run_ch(0, 5, 58, 1'b0);
      run_ch(1, 5, 116, 1'b0);
      run_ch(2, 5, 174, 1'b0);
      run_ch(3, 5, 232, 1'b0);
      run_ch(0, 5, 58, 1'b0);
      continuous = 1'b0;
      run_ch(1, 5, 116, 1'b0);
      run_ch(2, 5, 174, 1'b0);
      run_ch(3, 5, 232, 1'b0);
      repeat (GAP_US * Div + 20) @(negedge clk);
      check("cont_idle", 32'(busy), 32'd0);

      // Saturating echo, echo stuck high before trigger, reset during MEAS
      echo[1] = 1'b1;
      start_pulse();
      run_ch(0, 10, 3800, 1'b0);
      run_ch(1, 0, 0, 1'b1);
      echo[1] = 1'b0;
      n = 0;
      while (trig == '0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("meas_trig_ch2", 32'(trig), 32'd4);
      n = 0;
      while (trig != '0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      repeat (10) @(negedge clk);
      echo[2] = 1'b1;
      repeat (100) @(negedge clk);
      check("meas_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("meas_rst_trig", 32'(trig), 32'd0);
      check("meas_rst_busy", 32'(busy), 32'd0);
      check("meas_rst_distance", 32'(distance), 32'd0);
      check("meas_rst_timeout", 32'(timeout), 32'd0);
      model_reset();
      echo[2] = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Reset while trig is high drops it at once
      start_pulse();
      repeat (3) @(negedge clk);
      check("trig_before_rst", 32'(trig), 32'd1);
      rst_n = 1'b0;
      #1;
      check("trig_rst_async", 32'(trig), 32'd0);
      check("trig_rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
